// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: fetch FSM state encodings and the BF end-of-program byte
package instr_fetch_pkg;
  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_SKIP  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;
  localparam logic [7:0] BF_END  = 8'h00;
endpackage

// File: rtl/instr_fetch_loop_stack.sv
// bf_loop_stack: LIFO of loop return addresses; caller never pushes and pops together
module bf_loop_stack #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);
  localparam int SP_W = $clog2(DEPTH);
  localparam logic [SP_W:0] SP_ONE = 1;
  localparam logic [SP_W:0] SP_FULL = DEPTH[SP_W:0];
  localparam logic [SP_W-1:0] IDX_ONE = 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [SP_W:0] sp_q;
  assign full = sp_q == SP_FULL;
  assign empty = sp_q == '0;
  assign top = mem_q[sp_q[SP_W-1:0] - IDX_ONE];
  // Stack pointer; clearing it on reset empties the stack logically
  always_ff @(posedge clk or posedge rst)
    if (rst) sp_q <= '0;
    else sp_q <= push && !full ? sp_q + SP_ONE : pop && !empty ? sp_q - SP_ONE : sp_q;
  // Entry storage needs no reset since sp gates every read
  always_ff @(posedge clk)
    if (push && !full) mem_q[sp_q[SP_W-1:0]] <= din;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: BF fetch and loop-control stage; INSTR_COUNT_EN adds the retired_cnt port
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int STACK_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_data,
  output logic [7:0]        instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              loop_start,
  input  logic              loop_end,
  input  logic              data_zero,
  output logic              halt,
  output logic              err
`ifdef INSTR_COUNT_EN
  ,
  output logic [31:0]       retired_cnt
`endif
);
  localparam logic [ADDR_W:0] ONE = 1;
  logic [2:0] state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, top;
  logic [ADDR_W:0] depth_q, depth_d, pc_inc;
  logic [7:0] instr_q;
  logic err_q, err_d, push, pop, full, empty, retire, wrap, is_end;
  assign retire = state_q == S_EXEC && instr_ready;
  assign pc_inc = {1'b0, pc_q} + ONE;
  assign wrap = pc_inc[ADDR_W];
  assign is_end = instr_q == BF_END;
  assign imem_addr = pc_q;
  assign instr = instr_q;
  assign instr_valid = state_q == S_EXEC;
  assign halt = state_q == S_HALT;
  assign err = err_q;
  bf_loop_stack #(.WIDTH(ADDR_W), .DEPTH(STACK_DEPTH)) u_stack (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (pc_inc[ADDR_W-1:0]),
    .top  (top),
    .full (full),
    .empty(empty)
  );
  // Sequence fetch/load, resolve brackets on retire, track nesting depth while skipping
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    depth_d = depth_q;
    err_d = err_q;
    push = 1'b0;
    pop = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_LOAD;
      S_LOAD: state_d = depth_q == '0 ? S_EXEC : S_SKIP;
      S_EXEC:
        if (retire) begin
          if (is_end) state_d = S_HALT;
          else if ((loop_start && !data_zero && full) || (loop_end && empty)) begin
            err_d = 1'b1;
            state_d = S_HALT;
          end else if (loop_end && !data_zero) begin
            pc_d = top;
            state_d = S_FETCH;
          end else begin
            push = loop_start && !data_zero;
            pop = loop_end;
            depth_d = loop_start && data_zero ? ONE : depth_q;
            pc_d = wrap ? pc_q : pc_inc[ADDR_W-1:0];
            state_d = wrap ? S_HALT : S_FETCH;
          end
        end
      S_SKIP:
        if (is_end) begin
          err_d = 1'b1;
          state_d = S_HALT;
        end else begin
          depth_d = loop_start ? depth_q + ONE : loop_end ? depth_q - ONE : depth_q;
          pc_d = wrap ? pc_q : pc_inc[ADDR_W-1:0];
          state_d = wrap ? S_HALT : S_FETCH;
        end
      default: state_d = S_HALT;
    endcase
  end
  // State registers; instr captures the ROM byte at the end of LOAD
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_FETCH;
      pc_q <= '0;
      depth_q <= '0;
      err_q <= 1'b0;
      instr_q <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      depth_q <= depth_d;
      err_q <= err_d;
      instr_q <= state_q == S_LOAD ? imem_data : instr_q;
    end
`ifdef INSTR_COUNT_EN
  logic [31:0] cnt_q;
  // Count every retired instruction, the terminating 00 included
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= retire ? cnt_q + 32'd1 : cnt_q;
  assign retired_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed programs checked against a bracket-matching interpreter model
module tb_instr_fetch;
  localparam int AW = 5;
  localparam int AMAX = 31;
  localparam int STK = 16;
  localparam logic [7:0] LB = 8'h5B;
  localparam logic [7:0] RB = 8'h5D;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [AW-1:0] imem_addr;
  logic [7:0] imem_data;
  logic [7:0] instr;
  logic instr_valid, halt, err, loop_start, loop_end, data_zero;
  logic instr_ready = 1'b1;
`ifdef INSTR_COUNT_EN
  logic [31:0] retired_cnt;
`endif
  logic [7:0] rom [32];
  bit zs [64];
  logic [5:0] zi;
  bit rr = 1'b0;
  int total = 0, bad = 0, ri = 0, cyc = 0;
  int rc[$];
  logic [7:0] exp_b[$];
  int exp_p[$];
  int exp_pc;
  bit exp_err;

  instr_fetch #(.ADDR_W(AW), .STACK_DEPTH(STK)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .loop_start (loop_start),
    .loop_end   (loop_end),
    .data_zero  (data_zero),
    .halt       (halt),
    .err        (err)
`ifdef INSTR_COUNT_EN
    ,
    .retired_cnt(retired_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) imem_data <= rom[imem_addr];
  always @(posedge clk) cyc++;
  assign loop_start = instr == LB;
  assign loop_end = instr == RB;
  assign data_zero = zs[zi];
  always @(posedge clk or posedge rst)
    if (rst) zi <= '0;
    else if (instr_valid && instr_ready && (loop_start || loop_end)) zi <= zi + 6'd1;
  initial forever begin
    @(posedge clk);
    #2;
    instr_ready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, expv);
    end
  endtask

  always @(negedge clk or posedge rst)
    if (rst) begin
      ri = 0;
      rc.delete();
    end else if (instr_valid) begin
      if (ri < exp_b.size()) begin
        chk("instr", int'(instr), int'(exp_b[ri]));
        chk("pc", int'(imem_addr), exp_p[ri]);
      end else chk("extra_valid", int'(instr_valid), 0);
      if (instr_ready) begin
        ri++;
        rc.push_back(cyc);
      end
    end

  task automatic load(input string s);
    foreach (rom[i]) rom[i] = 8'h00;
    foreach (zs[i]) zs[i] = 1'b0;
    for (int i = 0; i < s.len(); i++) rom[i] = s[i];
  endtask

  task automatic model();
    int pc, d, k;
    int st[$];
    bit done, z;
    exp_b.delete();
    exp_p.delete();
    exp_err = 0;
    k = 0;
    pc = 0;
    done = 0;
    while (!done && exp_b.size() < 200) begin
      exp_b.push_back(rom[pc]);
      exp_p.push_back(pc);
      if (rom[pc] == 8'h00) done = 1;
      else if (rom[pc] == LB) begin
        z = zs[k];
        k++;
        if (!z) begin
          if (st.size() == STK) begin exp_err = 1; done = 1; end
          else begin
            st.push_back(pc + 1);
            if (pc == AMAX) done = 1; else pc++;
          end
        end else begin
          d = 1;
          while (d > 0 && !done) begin
            if (pc == AMAX) done = 1;
            else begin
              pc++;
              if (rom[pc] == 8'h00) begin exp_err = 1; done = 1; end
              else if (rom[pc] == LB) d++;
              else if (rom[pc] == RB) d--;
            end
          end
          if (!done) begin if (pc == AMAX) done = 1; else pc++; end
        end
      end else if (rom[pc] == RB) begin
        z = zs[k];
        k++;
        if (st.size() == 0) begin exp_err = 1; done = 1; end
        else if (!z) pc = st[$];
        else begin
          void'(st.pop_back());
          if (pc == AMAX) done = 1; else pc++;
        end
      end else if (pc == AMAX) done = 1;
      else pc++;
    end
    exp_pc = pc;
  endtask

  task automatic go();
    model();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic finish_chk(input string nm);
    int c = 0;
    while (!halt && c < 3000) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    chk({nm, ":halt"}, int'(halt), 1);
    chk({nm, ":err"}, int'(err), int'(exp_err));
    chk({nm, ":pc"}, int'(imem_addr), exp_pc);
    chk({nm, ":retires"}, ri, exp_b.size());
    chk({nm, ":valid"}, int'(instr_valid), 0);
`ifdef INSTR_COUNT_EN
    chk({nm, ":cnt"}, int'(retired_cnt), exp_b.size());
`endif
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    #1;
    chk("rst_valid", int'(instr_valid), 0);
    chk("rst_halt", int'(halt), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_pc", int'(imem_addr), 0);
    chk("rst_instr", int'(instr), 0);
    load("+>-");
    go();
    chk("m1_b1", int'(exp_b[1]), 8'h3E);
    chk("m1_n", exp_b.size(), 4);
    finish_chk("t1");
    for (int i = 1; i < 4; i++) chk("t1_cadence", rc[i] - rc[i-1], 3);
    load("[+]");
    zs[2] = 1'b1;
    go();
    chk("m2_pc3", exp_p[3], 1);
    chk("m2_n", exp_b.size(), 6);
    finish_chk("t2");
    load("[+]");
    zs[2] = 1'b1;
    rr = 1'b1;
    go();
    finish_chk("t2_stall");
    rr = 1'b0;
    load("[[+]-]+");
    zs[0] = 1'b1;
    go();
    chk("m3_pc1", exp_p[1], 6);
    chk("m3_b1", int'(exp_b[1]), 8'h2B);
    finish_chk("t3");
    load("");
    for (int i = 0; i < 17; i++) rom[i] = LB;
    go();
    chk("m4_pc", exp_pc, 16);
    finish_chk("t4");
    chk("t4_pc_lit", int'(imem_addr), 16);
    chk("t4_err_lit", int'(err), 1);
    load("]");
    go();
    finish_chk("t5a");
    chk("t5a_err_lit", int'(err), 1);
    load("[+");
    zs[0] = 1'b1;
    go();
    chk("m5b_pc", exp_pc, 2);
    finish_chk("t5b");
    load("");
    foreach (rom[i]) rom[i] = 8'h2B;
    go();
    finish_chk("wrap");
    chk("wrap_pc_lit", int'(imem_addr), AMAX);
    chk("wrap_err_lit", int'(err), 0);
    load("[[+]]");
    zs[2] = 1'b1;
    zs[3] = 1'b1;
    go();
    begin
      int c = 0;
      @(negedge clk);
      while (!(instr_valid && instr == 8'h2B) && c < 200) begin
        @(negedge clk);
        c++;
      end
      chk("t6_reach_plus", int'(instr), 8'h2B);
    end
    #1;
    rst = 1'b1;
    #1;
    chk("t6_valid", int'(instr_valid), 0);
    chk("t6_instr", int'(instr), 0);
    chk("t6_pc", int'(imem_addr), 0);
    chk("t6_halt", int'(halt), 0);
    chk("t6_err", int'(err), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    finish_chk("t6_rerun");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
